// File: rtl/adc_uart_sched.sv
// adc_uart_sched
// Captures main/sub ADC results into a sample FIFO and sends them over a byte UART
// as frames: HEADER, FRAME_LEN tagged samples and, optionally, an XOR checksum byte.
// Main samples are tagged 2'b11 and sub samples 2'b00 in the top two bits.
//
// Optional feature: define SCHED_CHECKSUM_EN to append the checksum byte (XOR of the
// header and all data bytes of the frame). Without it a frame is FRAME_LEN + 1 bytes.
//
// Ports:
//   clk_50M     in   sole clock
//   nrst        in   asynchronous active-low reset
//   adc_ack     in   main-ADC done (asynchronous, synchronized here)
//   adc_ack_sub in   sub-ADC done (asynchronous, synchronized here)
//   dout_adc    in   ADC result, stable while either ack is high
//   uart_rdy    in   UART transmitter idle
//   wreq        out  one-cycle UART write strobe
//   wdata       out  UART byte, valid with wreq
//   fifo_level  out  sample FIFO occupancy
//   overflow    out  sticky: a sample was dropped on a full FIFO
//   busy        out  scheduler not idle
module adc_uart_sched #(
    parameter int unsigned       N_bit      = 6,
    parameter int unsigned       N_data     = 8,
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter int unsigned       FRAME_LEN  = 8,
    parameter logic [N_data-1:0] HEADER     = 8'hA5
) (
    input  logic                          clk_50M,
    input  logic                          nrst,
    input  logic                          adc_ack,
    input  logic                          adc_ack_sub,
    input  logic [N_bit-1:0]              dout_adc,
    input  logic                          uart_rdy,
    output logic                          wreq,
    output logic [N_data-1:0]             wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
);

    localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned   LW        = AW + 1;
    localparam int unsigned   CW        = $clog2(FRAME_LEN + 1);
    localparam logic [LW-1:0] DepthL    = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] FrameLenL = LW'(FRAME_LEN);
    localparam logic [CW-1:0] LastIdx   = CW'(FRAME_LEN - 1);

`ifdef SCHED_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StHdr, StData, StCsum, StWait} state_e;
`else
    typedef enum logic [2:0] {StIdle, StHdr, StData, StWait} state_e;
`endif

    state_e r_state, w_state_nxt;
    state_e r_ret, w_ret_nxt;      // state to resume once WAIT sees the UART cycle
    logic   r_seen_low, w_seen_low_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    // Ack synchronizers; bit 2 is the previous synchronized value for edge detection.
    logic [2:0] r_main_sync, r_sub_sync;
    logic       w_main_edge, w_sub_edge;

    always_ff @(posedge clk_50M or negedge nrst) begin
        if (!nrst) begin
            r_main_sync <= '0;
            r_sub_sync  <= '0;
        end else begin
            r_main_sync <= {r_main_sync[1:0], adc_ack};
            r_sub_sync  <= {r_sub_sync[1:0], adc_ack_sub};
        end
    end

    assign w_main_edge = r_main_sync[1] & ~r_main_sync[2];
    assign w_sub_edge  = r_sub_sync[1] & ~r_sub_sync[2];

    // Sample FIFO
    logic [N_data-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_overflow;
    logic              w_push, w_pop, w_full, w_push_ok;
    logic [N_data-1:0] w_push_word;

    assign w_push      = w_main_edge | w_sub_edge;
    // A simultaneous sub edge is discarded in favour of the main sample.
    assign w_push_word = w_main_edge ? {2'b11, dout_adc} : {2'b00, dout_adc};
    assign w_full      = (r_level == DepthL);
    assign w_pop       = (r_state == StData) && uart_rdy;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk_50M) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk_50M or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push_ok && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

`ifdef SCHED_CHECKSUM_EN
    logic [N_data-1:0] r_csum;

    always_ff @(posedge clk_50M or negedge nrst) begin
        if (!nrst) begin
            r_csum <= '0;
        end else if (r_state == StHdr && uart_rdy) begin
            r_csum <= HEADER;
        end else if (w_pop) begin
            r_csum <= r_csum ^ r_mem[r_rd_ptr];
        end
    end
`endif

    // Scheduler FSM: wreq is combinational on uart_rdy so it can never fire while busy.
    always_comb begin
        w_state_nxt    = r_state;
        w_ret_nxt      = r_ret;
        w_seen_low_nxt = r_seen_low;
        w_cnt_nxt      = r_cnt;
        wreq           = 1'b0;
        wdata          = '0;
        unique case (r_state)
            StIdle: begin
                if (r_level >= FrameLenL) w_state_nxt = StHdr;
            end
            StHdr: begin
                if (uart_rdy) begin
                    wreq           = 1'b1;
                    wdata          = HEADER;
                    w_cnt_nxt      = '0;
                    w_ret_nxt      = StData;
                    w_seen_low_nxt = 1'b0;
                    w_state_nxt    = StWait;
                end
            end
            StData: begin
                if (uart_rdy) begin
                    wreq           = 1'b1;
                    wdata          = r_mem[r_rd_ptr];
                    w_cnt_nxt      = r_cnt + 1'b1;
`ifdef SCHED_CHECKSUM_EN
                    w_ret_nxt      = (r_cnt == LastIdx) ? StCsum : StData;
`else
                    w_ret_nxt      = (r_cnt == LastIdx) ? StIdle : StData;
`endif
                    w_seen_low_nxt = 1'b0;
                    w_state_nxt    = StWait;
                end
            end
`ifdef SCHED_CHECKSUM_EN
            StCsum: begin
                if (uart_rdy) begin
                    wreq           = 1'b1;
                    wdata          = r_csum;
                    w_ret_nxt      = StIdle;
                    w_seen_low_nxt = 1'b0;
                    w_state_nxt    = StWait;
                end
            end
`endif
            StWait: begin
                // The UART must visibly take the byte (rdy low) before it is idle again.
                if (!uart_rdy) begin
                    w_seen_low_nxt = 1'b1;
                end else if (r_seen_low) begin
                    w_state_nxt = r_ret;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_50M or negedge nrst) begin
        if (!nrst) begin
            r_state    <= StIdle;
            r_ret      <= StIdle;
            r_seen_low <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ret      <= w_ret_nxt;
            r_seen_low <= w_seen_low_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign busy       = (r_state != StIdle);

endmodule
